fft_pingpong_buffer: RTL and testbench
======================================

FFT_PINGPONG_BUFFER -- requirements
Module: fft_pingpong_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, log2 of words per bank; bank depth N = 2^ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  write sample offered.
REQ-006 wr_data  input  DATA_WIDTH  write sample.
REQ-007 wr_ready  output  1  buffer can accept a write this cycle.
REQ-008 rd_ready  input  1  consumer accepts the read sample this cycle.
REQ-009 rd_valid  output  1  rd_data holds a valid sample.
REQ-010 rd_data  output  DATA_WIDTH  read sample, registered.
REQ-011 rd_last  output  1  high with the final sample (index N-1) of a bank.
REQ-012 bank_full  output  2  bit b high while bank b holds a complete, unread frame.

Function
REQ-013 Two banks of N words each; the write bank (wsel) and read bank (rsel) are independent 1-bit pointers.
REQ-014 Write accepted when wr_valid && wr_ready; word stored at wsel bank, address wcnt; wcnt increments modulo N.
REQ-015 wr_ready = !bank_full[wsel].
REQ-016 Write at wcnt = N-1: same edge sets bank_full[wsel], toggles wsel, wraps wcnt to 0.
REQ-017 Read engine states: IDLE, FETCH, STREAM.
REQ-018 IDLE -> FETCH when bank_full[rsel]; FETCH issues the synchronous RAM read of index 0 (1-cycle RAM latency).
REQ-019 A sample is handed over when rd_valid && rd_ready; the output register reloads when !rd_valid || rd_ready, so a full-rate stream carries no bubbles.
REQ-020 rd_data/rd_valid hold stable while rd_valid && !rd_ready.
REQ-021 Timing: last write accepted at edge T -> bank_full set after T -> rd_valid high after edge T+2 with sample index 0.
REQ-022 Handshake of the rd_last sample: same edge clears bank_full[rsel], toggles rsel, rcnt -> 0; engine -> FETCH if the other bank is full, else IDLE, with rd_valid low in both cases.
REQ-023 Same-edge completion of a write bank and release of the read bank: both updates take effect; neither is lost.
REQ-024 Both banks full: wr_ready low; writes blocked until release.
REQ-025 Memory contents are not reset and are never read before being written in the current frame.

Reset
REQ-026 With reset high at an edge: wsel = rsel = 0, wcnt = rcnt = 0, bank_full = 2'b00, state IDLE, rd_valid = 0, rd_last = 0, rd_data = 0; wr_ready reads 1 from the following cycle.
REQ-027 Reset mid-frame discards partial and unread frames; writes presented during reset are ignored.

Configuration
REQ-028 Macro BITREV_READ_EN defined: read address = bit-reverse of rcnt over ADDR_WIDTH bits (FFT input reorder).
REQ-029 Macro BITREV_READ_EN undefined: read address = rcnt (natural order); no other behavioural difference.
REQ-030 rd_last keys on rcnt = N-1 in both builds.

Verification (ADDR_WIDTH = 3, DATA_WIDTH = 16)
REQ-031 Write 0..7 back-to-back with rd_ready = 1 -> rd_valid 2 cycles after the last write; output 0..7 (macro off) or 0,4,2,6,1,5,3,7 (macro on); rd_last with the 8th sample.
REQ-032 Write 16 samples 0..15 with rd_ready = 0 -> bank_full = 2'b11, wr_ready = 0; 17th write not accepted; then rd_ready = 1 -> 16 samples out in order across both banks.
REQ-033 Toggle rd_ready every cycle during a read -> each sample held stable until accepted; no duplicates or drops.
REQ-034 Write a second frame while the first drains, final write on the same edge as first-frame rd_last -> both bank_full updates applied; second frame streams after FETCH.
REQ-035 Assert reset after 5 writes, then write 8 samples 0x100..0x107 -> only 0x100..0x107 read out; no stale data.

Source files
------------

// File: rtl/fft_pingpong_buffer.sv
// rtl/fft_pingpong_buffer.sv - two-bank ping-pong frame buffer feeding an FFT core.
// Define BITREV_READ_EN to read each bank in bit-reversed address order.
module fft_pingpong_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            bank_full
);

  localparam int                    N        = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [0:2*N-1];
  logic                    r_wsel;
  logic                    r_rsel;
  logic [ADDR_WIDTH-1:0]   r_wcnt;
  logic [ADDR_WIDTH-1:0]   r_rcnt;
  logic [1:0]              r_bank_full;
  logic                    r_rd_valid;
  logic                    r_rd_last;
  logic [DATA_WIDTH-1:0]   r_rd_data;

  logic                    w_wr_fire;
  logic                    w_wr_done;
  logic                    w_rd_fire;
  logic                    w_load;
  logic                    w_release;
  logic [ADDR_WIDTH-1:0]   w_load_idx;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic [1:0]              w_bank_full_nxt;

  assign wr_ready  = !r_bank_full[r_wsel];
  assign w_wr_fire = wr_valid && wr_ready && !reset;
  assign w_wr_done = w_wr_fire && (r_wcnt == LAST_IDX);
  assign w_rd_fire = r_rd_valid && rd_ready;

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign bank_full = r_bank_full;

`ifdef BITREV_READ_EN
  function automatic logic [ADDR_WIDTH-1:0] f_bitrev(input logic [ADDR_WIDTH-1:0] a);
    for (int i = 0; i < ADDR_WIDTH; i++) f_bitrev[i] = a[ADDR_WIDTH-1-i];
  endfunction
  assign w_rd_addr = f_bitrev(w_load_idx);
`else
  assign w_rd_addr = w_load_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_rcnt is the index of the sample sitting in the output register.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = r_rcnt;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_bank_full[r_rsel]) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_load      = 1'b1;
        w_load_idx  = '0;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_rd_fire) begin
          if (r_rcnt == LAST_IDX) begin
            w_release   = 1'b1;
            w_state_nxt = r_bank_full[!r_rsel] ? S_FETCH : S_IDLE;
          end else begin
            w_load     = 1'b1;
            w_load_idx = r_rcnt + ADDR_WIDTH'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Release and completion always target different banks, so both apply.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_release) w_bank_full_nxt[r_rsel] = 1'b0;
    if (w_wr_done) w_bank_full_nxt[r_wsel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[{r_wsel, r_wcnt}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_bank_full <= 2'b00;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      if (w_wr_fire) begin
        r_wcnt <= r_wcnt + ADDR_WIDTH'(1);
        if (w_wr_done) r_wsel <= !r_wsel;
      end
      if (w_load) begin
        r_rd_data  <= r_mem[{r_rsel, w_rd_addr}];
        r_rd_valid <= 1'b1;
        r_rd_last  <= (w_load_idx == LAST_IDX);
        r_rcnt     <= w_load_idx;
      end else if (w_release) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
        r_rcnt     <= '0;
        r_rsel     <= !r_rsel;
      end
    end
  end

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// tb/tb_fft_pingpong_buffer.sv - self-checking bench for fft_pingpong_buffer (8-word banks).
module tb_fft_pingpong_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic [1:0]  bank_full;

  int n_checks = 0;
  int n_errors = 0;

  fft_pingpong_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  function automatic int perm(input int i);
`ifdef BITREV_READ_EN
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
`else
    return i;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames collected from accepted writes, emitted in read order.
  typedef struct { logic [15:0] d; logic l; } smp_t;
  smp_t        exp_q[$];
  logic [15:0] part[$];
  int          full_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      part.delete();
      full_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      chk("wr_ready_model", {31'd0, wr_ready}, {31'd0, full_cnt < 2});
      chk("bank_count", $countones(bank_full), full_cnt);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, rd_valid}, 32'd1);
        chk("hold_data", {16'd0, rd_data}, {16'd0, prev_data});
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", {16'd0, rd_data}, 32'hFFFF_FFFF);
        end else begin
          chk("stream_data", {16'd0, rd_data}, {16'd0, exp_q[0].d});
          chk("stream_last", {31'd0, rd_last}, {31'd0, exp_q[0].l});
          if (exp_q[0].l) full_cnt--;
          void'(exp_q.pop_front());
        end
      end
      if (wr_valid && wr_ready) begin
        part.push_back(wr_data);
        if (part.size() == 8) begin
          for (int i = 0; i < 8; i++) exp_q.push_back('{d: part[perm(i)], l: (i == 7)});
          full_cnt++;
          part.delete();
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
  end

  task automatic step(input logic wv, input logic [15:0] wd, input logic rr);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'h0BAD;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    wr_valid = 1'b0;
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    chk("rst_bank_full", {30'd0, bank_full}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) step(1'b0, 16'h0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", {31'd0, rd_valid}, 32'd0);
    chk("drain_bank_full", {30'd0, bank_full}, 32'd0);
  endtask

  typedef struct {
    logic wv; logic [15:0] wd; logic rr;
    logic ewr; logic ev; logic [15:0] ed; logic el;
  } vec_t;
  vec_t tbl [18];

  initial begin
    for (int k = 0; k < 18; k++) begin
      tbl[k].wv  = (k < 8);
      tbl[k].wd  = 16'(k);
      tbl[k].rr  = 1'b1;
      tbl[k].ewr = 1'b1;
      tbl[k].ev  = (k >= 9 && k <= 16);
      tbl[k].ed  = tbl[k].ev ? 16'(perm(k - 9)) : 16'h0;
      tbl[k].el  = (k == 16);
    end

    // Single frame at full rate: first sample two edges after the last write.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].wv, tbl[k].wd, tbl[k].rr);
      chk($sformatf("tbl%0d_wr_ready", k), {31'd0, wr_ready}, {31'd0, tbl[k].ewr});
      chk($sformatf("tbl%0d_rd_valid", k), {31'd0, rd_valid}, {31'd0, tbl[k].ev});
      chk($sformatf("tbl%0d_rd_last", k), {31'd0, rd_last}, {31'd0, tbl[k].el});
      if (tbl[k].ev) chk($sformatf("tbl%0d_rd_data", k), {16'd0, rd_data}, {16'd0, tbl[k].ed});
    end

    // Both banks full: writes blocked, then 16 samples drain across both banks.
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, 16'(k), 1'b0);
    chk("full_bank_full", {30'd0, bank_full}, 32'd3);
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    step(1'b1, 16'hDEAD, 1'b0);
    chk("full_17th_blocked", {31'd0, wr_ready}, 32'd0);
    chk("full_held_data", {16'd0, rd_data}, {16'd0, 16'(perm(0))});
    drain();

    // Second frame completes on the same edge the first frame's last sample leaves.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      if (k < 8)       step(1'b1, 16'(16'h20 + k), 1'b1);
      else if (k < 10) step(1'b0, 16'h0, 1'b1);
      else             step(1'b1, 16'(16'h40 + k - 10), 1'b1);
    end
    chk("same_edge_bank_full", {30'd0, bank_full}, 32'd2);
    chk("same_edge_rd_valid", {31'd0, rd_valid}, 32'd0);
    step(1'b0, 16'h0, 1'b1);
    chk("same_edge_fetch_gap", {31'd0, rd_valid}, 32'd0);
    step(1'b0, 16'h0, 1'b1);
    chk("same_edge_second_valid", {31'd0, rd_valid}, 32'd1);
    chk("same_edge_second_data", {16'd0, rd_data}, {16'd0, 16'(16'h40 + perm(0))});
    drain();

    // Reset mid-frame discards the partial frame.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'h50 + k), 1'b1);
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 16'(16'h100 + k), 1'b1);
    drain();

    // Random traffic against the frame model.
    do_reset();
    for (int k = 0; k < 400; k++)
      step(($urandom % 10) < 6, 16'($urandom), ($urandom % 4) != 0);
    drain();

    // rd_ready toggling every cycle while writes stream in.
    do_reset();
    for (int k = 0; k < 120; k++) step(1'b1, 16'($urandom), k[0]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
